// File: rtl/sad_pkg.sv
// Shared definitions for the SAD candidate scanner and the min-SAD register.
// Latency: n/a (package: default geometry, clog2 helper, scanner state encoding).
// Backpressure: n/a.
package sad_pkg;

    localparam int DEF_FRAME_W = 64;
    localparam int DEF_FRAME_H = 64;
    localparam int DEF_BLK_W   = 4;
    localparam int DEF_BLK_H   = 4;
    localparam int DEF_PIX_W   = 8;
    localparam int DEF_SAD_W   = 32;
    localparam int DEF_COORD_W = 8;

    // Ceiling log2; 1 for v<=2 so that address ports are never zero-width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        SCAN_IDLE  = 3'd0,
        SCAN_FETCH = 3'd1,
        SCAN_DRAIN = 3'd2,
        SCAN_EMIT  = 3'd3,
        SCAN_DONE  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/sad_absdiff_acc.sv
// Absolute difference of two pixels added into a SAD accumulator with clear/enable.
// Latency: 1 cycle (AccOut reflects an enabled sample on the following cycle).
// Backpressure: none; caller gates with En, Clr has priority.
// Ports: Clk, Rst_n (sync, active-low), Clr, En, PixA, PixB, AccOut.
module sad_absdiff_acc #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Clr,
    input  logic             En,
    input  logic [PIX_W-1:0] PixA,
    input  logic [PIX_W-1:0] PixB,
    output logic [SAD_W-1:0] AccOut
);

    logic [PIX_W:0] diff;
    logic [PIX_W:0] absd;

    // One extra bit so the sign of PixA-PixB is visible.
    always_comb begin
        diff = {1'b0, PixA} - {1'b0, PixB};
        absd = diff[PIX_W] ? (~diff + 1'b1) : diff;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            AccOut <= '0;
        end else if (Clr) begin
            AccOut <= '0;
        end else if (En) begin
            AccOut <= AccOut + {{(SAD_W-PIX_W-1){1'b0}}, absd};
        end
    end

endmodule

// File: rtl/sad_candidate_scanner.sv
// Sweeps every block position of the frame, emitting one (SAD,row,col) per position.
// Latency: BLK_W*BLK_H+2 cycles per candidate; first SADValid N+2 cycles after Start.
// Backpressure: none; consumer must accept every SADValid strobe.
// Ports: Clk, Rst_n (sync, active-low), Start, FrameAddr/TmplAddr (to sync RAMs),
//        FramePixel/TmplPixel (1-cycle RAM data), SADOut/SADRowOut/SADColumnOut/SADValid,
//        Busy, Done.
module sad_candidate_scanner
    import sad_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int BLK_W   = DEF_BLK_W,
    parameter int BLK_H   = DEF_BLK_H,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int SAD_W   = DEF_SAD_W,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic                                Clk,
    input  logic                                Rst_n,
    input  logic                                Start,
    output logic [clog2(FRAME_W*FRAME_H)-1:0]   FrameAddr,
    output logic [clog2(BLK_W*BLK_H)-1:0]       TmplAddr,
    input  logic [PIX_W-1:0]                    FramePixel,
    input  logic [PIX_W-1:0]                    TmplPixel,
    output logic [SAD_W-1:0]                    SADOut,
    output logic [COORD_W-1:0]                  SADRowOut,
    output logic [COORD_W-1:0]                  SADColumnOut,
    output logic                                SADValid,
    output logic                                Busy,
    output logic                                Done
);

    localparam int FA_W   = clog2(FRAME_W*FRAME_H);
    localparam int TA_W   = clog2(BLK_W*BLK_H);
    localparam int LAST_R = FRAME_H - BLK_H;
    localparam int LAST_C = FRAME_W - BLK_W;

    scan_state_t        state_q, state_d;
    logic [COORD_W-1:0] r_q, r_d, c_q, c_d;
    logic [COORD_W-1:0] i_q, i_d, j_q, j_d;
    logic               rd_vld_q;
    logic               acc_clr;
    logic [SAD_W-1:0]   acc;

    sad_absdiff_acc #(
        .PIX_W (PIX_W),
        .SAD_W (SAD_W)
    ) u_acc (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Clr    (acc_clr),
        .En     (rd_vld_q),
        .PixA   (FramePixel),
        .PixB   (TmplPixel),
        .AccOut (acc)
    );

    // Next-state and next-index logic. Indices always point at the pixel
    // whose address is being presented this cycle.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_clr = 1'b0;
        case (state_q)
            SCAN_IDLE: begin
                if (Start) begin
                    state_d = SCAN_FETCH;
                    r_d     = '0;
                    c_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            SCAN_FETCH: begin
                if (j_q == COORD_W'(BLK_W-1)) begin
                    j_d = '0;
                    if (i_q == COORD_W'(BLK_H-1)) begin
                        i_d     = '0;
                        state_d = SCAN_DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            SCAN_DRAIN: begin
                state_d = SCAN_EMIT;
            end
            SCAN_EMIT: begin
                acc_clr = 1'b1;
                state_d = SCAN_FETCH;
                if (c_q == COORD_W'(LAST_C)) begin
                    c_d = '0;
                    if (r_q == COORD_W'(LAST_R)) begin
                        r_d     = '0;
                        state_d = SCAN_DONE;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            SCAN_DONE: begin
                state_d = SCAN_IDLE;
            end
            default: begin
                state_d = SCAN_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= SCAN_IDLE;
            r_q          <= '0;
            c_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            rd_vld_q     <= 1'b0;
            FrameAddr    <= '0;
            TmplAddr     <= '0;
            SADOut       <= '0;
            SADRowOut    <= '0;
            SADColumnOut <= '0;
            SADValid     <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            i_q      <= i_d;
            j_q      <= j_d;
            // RAM data lands one cycle after each FETCH address.
            rd_vld_q <= (state_q == SCAN_FETCH);

            // Addresses are loaded for the pixel issued next cycle and
            // otherwise hold.
            if (state_d == SCAN_FETCH) begin
                FrameAddr <= FA_W'((int'(r_d) + int'(i_d)) * FRAME_W + int'(c_d) + int'(j_d));
                TmplAddr  <= TA_W'(int'(i_d) * BLK_W + int'(j_d));
            end

            SADValid <= (state_q == SCAN_EMIT);
            if (state_q == SCAN_EMIT) begin
                SADOut       <= acc;
                SADRowOut    <= r_q;
                SADColumnOut <= c_q;
            end

            Done <= (state_q == SCAN_DONE);
            if (state_q == SCAN_IDLE && Start) begin
                Busy <= 1'b1;
            end else if (state_q == SCAN_DONE) begin
                Busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sad_candidate_scanner.sv
module tb_sad_candidate_scanner;

    localparam int FW = 8;
    localparam int FH = 8;
    localparam int BW = 2;
    localparam int BH = 2;
    localparam int NC = (FW-BW+1) * (FH-BH+1);
    localparam int NCOL = FW-BW+1;
    localparam int MAXC = 1000;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [5:0]  FrameAddr;
    logic [1:0]  TmplAddr;
    logic [7:0]  FramePixel;
    logic [7:0]  TmplPixel;
    logic [31:0] SADOut;
    logic [7:0]  SADRowOut;
    logic [7:0]  SADColumnOut;
    logic        SADValid;
    logic        Busy;
    logic        Done;

    always #5 Clk = ~Clk;

    sad_candidate_scanner #(
        .FRAME_W (FW), .FRAME_H (FH), .BLK_W (BW), .BLK_H (BH),
        .PIX_W (8), .SAD_W (32), .COORD_W (8)
    ) dut (
        .Clk (Clk), .Rst_n (Rst_n), .Start (Start),
        .FrameAddr (FrameAddr), .TmplAddr (TmplAddr),
        .FramePixel (FramePixel), .TmplPixel (TmplPixel),
        .SADOut (SADOut), .SADRowOut (SADRowOut), .SADColumnOut (SADColumnOut),
        .SADValid (SADValid), .Busy (Busy), .Done (Done)
    );

    // Synchronous RAMs: data one cycle after address.
    logic [7:0] frame_mem [FW*FH];
    logic [7:0] tmpl_mem  [BW*BH];
    always @(posedge Clk) begin
        FramePixel <= frame_mem[FrameAddr];
        TmplPixel  <= tmpl_mem[TmplAddr];
    end

    int errors = 0;
    int checks = 0;

    int obs_sad [$];
    int obs_row [$];
    int obs_col [$];
    int obs_cyc [$];
    int done_cnt;
    int done_cyc;
    int fa_log [MAXC];
    int ta_log [MAXC];

    // Reference: SAD of the template against the frame at (r,c).
    function automatic int ref_sad(input int r, input int c);
        int s = 0;
        for (int i = 0; i < BH; i++)
            for (int j = 0; j < BW; j++) begin
                int a = frame_mem[(r+i)*FW + c+j];
                int b = tmpl_mem[i*BW + j];
                s += (a > b) ? a - b : b - a;
            end
        return s;
    endfunction

    // Pulses Start, then records every cycle (sample t = half a cycle after
    // the t-th edge following the Start edge) until 20 cycles past Done.
    task automatic run_scan(input int extra_start_at);
        obs_sad.delete(); obs_row.delete(); obs_col.delete(); obs_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        for (int t = 0; t < MAXC; t++) begin
            if (t > 0) @(negedge Clk);
            if (SADValid) begin
                obs_sad.push_back(int'(SADOut));
                obs_row.push_back(int'(SADRowOut));
                obs_col.push_back(int'(SADColumnOut));
                obs_cyc.push_back(t);
            end
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = t;
            end
            fa_log[t] = int'(FrameAddr);
            ta_log[t] = int'(TmplAddr);
            Start = (t == extra_start_at);
            if (done_cyc >= 0 && t >= done_cyc + 20) break;
        end
        Start = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL scan_timeout: Done never seen within %0d cycles", MAXC);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({SADValid, Busy, Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got V/B/D=%b%b%b want 000", SADValid, Busy, Done);
        end
        checks++;
        if (SADOut !== 32'd0 || SADRowOut !== 8'd0 || SADColumnOut !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got sad=%0d row=%0d col=%0d want 0", SADOut, SADRowOut, SADColumnOut);
        end
        checks++;
        if (FrameAddr !== 6'd0 || TmplAddr !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr: got fa=%0d ta=%0d want 0", FrameAddr, TmplAddr);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_pattern();
        for (int k = 0; k < FW*FH; k++) frame_mem[k] = 8'd0;
        for (int k = 0; k < BW*BH; k++) tmpl_mem[k] = 8'd10;
        for (int r = 3; r <= 4; r++)
            for (int c = 5; c <= 6; c++) frame_mem[r*FW + c] = 8'd10;
        run_scan(-1);
        checks++;
        if (obs_sad.size() != NC) begin
            errors++;
            $display("FAIL pat_count: got %0d strobes want %0d", obs_sad.size(), NC);
        end
        checks++;
        if (done_cyc != 295 || done_cnt != 1) begin
            errors++;
            $display("FAIL pat_done: got cycle %0d count %0d want 295 / 1", done_cyc, done_cnt);
        end
        checks++;
        if (obs_cyc.size() < 1 || obs_cyc[0] != 6) begin
            errors++;
            $display("FAIL pat_first_valid: got cycle %0d want 6", obs_cyc.size() > 0 ? obs_cyc[0] : -1);
        end
        checks++;
        if (obs_sad.size() < NC || obs_sad[0] != 40 || obs_sad[3*NCOL+5] != 0) begin
            errors++;
            $display("FAIL pat_corner: (0,0)/(3,5) SAD not 40/0");
        end
        checks++;
        if (obs_row.size() < NC || obs_row[6] != 0 || obs_col[6] != 6 || obs_row[7] != 1 ||
            obs_col[7] != 0 || obs_row[NC-1] != 6 || obs_col[NC-1] != 6) begin
            errors++;
            $display("FAIL pat_wrap: row/col wrap sequence (0,6)->(1,0) ... (6,6) not seen");
        end
        for (int k = 0; k < obs_sad.size(); k++) begin
            checks++;
            if (obs_row[k] != k / NCOL || obs_col[k] != k % NCOL || obs_sad[k] != ref_sad(k / NCOL, k % NCOL)
                || obs_cyc[k] != 6*(k+1)) begin
                errors++;
                $display("FAIL pat_cand%0d: got (%0d,%0d) sad=%0d t=%0d want (%0d,%0d) sad=%0d t=%0d", k,
                         obs_row[k], obs_col[k], obs_sad[k], obs_cyc[k],
                         k / NCOL, k % NCOL, ref_sad(k / NCOL, k % NCOL), 6*(k+1));
            end
        end
        // Candidate (2,3) is index 17; its four fetch cycles begin at 6*17.
        for (int m = 0; m < 4; m++) begin
            int efa = (2 + m/2)*FW + 3 + m%2;
            checks++;
            if (fa_log[102+m] != efa || ta_log[102+m] != m) begin
                errors++;
                $display("FAIL addr_2_3_%0d: got fa=%0d ta=%0d want fa=%0d ta=%0d", m,
                         fa_log[102+m], ta_log[102+m], efa, m);
            end
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < FW*FH; k++) frame_mem[k] = 8'd255;
        for (int k = 0; k < BW*BH; k++) tmpl_mem[k] = 8'd0;
        run_scan(-1);
        checks++;
        if (obs_sad.size() != NC) begin
            errors++;
            $display("FAIL sat_count: got %0d want %0d", obs_sad.size(), NC);
        end
        for (int k = 0; k < obs_sad.size(); k++) begin
            checks++;
            if (obs_sad[k] != 1020) begin
                errors++;
                $display("FAIL sat_cand%0d: got sad=%0d want 1020", k, obs_sad[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < FW*FH; k++) frame_mem[k] = 8'($urandom_range(0, 255));
            for (int k = 0; k < BW*BH; k++) tmpl_mem[k] = 8'($urandom_range(0, 255));
            run_scan(-1);
            checks++;
            if (obs_sad.size() != NC) begin
                errors++;
                $display("FAIL rnd_count: got %0d want %0d", obs_sad.size(), NC);
            end
            for (int k = 0; k < obs_sad.size(); k++) begin
                checks++;
                if (obs_sad[k] != ref_sad(k / NCOL, k % NCOL) || obs_row[k] != k / NCOL || obs_col[k] != k % NCOL) begin
                    errors++;
                    $display("FAIL rnd_cand%0d: got (%0d,%0d) sad=%0d want (%0d,%0d) sad=%0d", k,
                             obs_row[k], obs_col[k], obs_sad[k], k / NCOL, k % NCOL, ref_sad(k / NCOL, k % NCOL));
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        run_scan(6*5 + 2);
        checks++;
        if (obs_sad.size() != NC || done_cnt != 1) begin
            errors++;
            $display("FAIL start_ignored: got %0d strobes %0d dones want %0d / 1", obs_sad.size(), done_cnt, NC);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_busy: got Busy=%b want 0 after Done", Busy);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        @(negedge Clk) Start = 1'b1;
        @(negedge Clk) Start = 1'b0;
        repeat (6*10 + 2) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        checks++;
        if ({SADValid, Busy, Done} !== 3'b000 || SADOut !== 32'd0 || SADRowOut !== 8'd0 ||
            SADColumnOut !== 8'd0 || FrameAddr !== 6'd0 || TmplAddr !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got V/B/D=%b%b%b sad=%0d row=%0d col=%0d fa=%0d ta=%0d want all 0",
                     SADValid, Busy, Done, SADOut, SADRowOut, SADColumnOut, FrameAddr, TmplAddr);
        end
        for (int t = 0; t < 30; t++) begin
            @(negedge Clk);
            if (SADValid || Done || Busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d active cycles want 0", stray);
        end
        run_scan(-1);
        checks++;
        if (obs_sad.size() != NC || obs_row[0] != 0 || obs_col[0] != 0 || obs_sad[0] != ref_sad(0, 0)) begin
            errors++;
            $display("FAIL rst_mid_rescan: got %0d strobes first (%0d,%0d) want %0d from (0,0)",
                     obs_sad.size(), obs_sad.size() > 0 ? obs_row[0] : -1,
                     obs_sad.size() > 0 ? obs_col[0] : -1, NC);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_saturate();
        test_random();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
